// File: rtl/ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctrl_seq                                                     |
// | Description : Multi-cycle control sequencer (IDLE/DEC/MEM/EXEC) for the     |
// |               8-bit datapath. Optional macro CTRL_SEQ_MEMWAIT_EN adds the   |
// |               mem_ack port and stretches MEM until the read completes.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ctrl_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ins_valid,
    output logic        ins_ready,
    input  logic [3:0]  ins_op,
    input  logic        ins_dst,
    input  logic        flag_z,
`ifdef CTRL_SEQ_MEMWAIT_EN
    input  logic        mem_ack,
`endif
    output logic [1:0]  sel_a,
    output logic [1:0]  sel_b,
    output logic [2:0]  alu_op,
    output logic        ld_a,
    output logic        ld_b,
    output logic        mem_we,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        MEM  = 2'd2,
        EXEC = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_MOVK = 4'h1;
    localparam logic [3:0] c_OP_ADD  = 4'h2;
    localparam logic [3:0] c_OP_SUB  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_INC  = 4'h6;
    localparam logic [3:0] c_OP_LD   = 4'h7;
    localparam logic [3:0] c_OP_ST   = 4'h8;
    localparam logic [3:0] c_OP_JMP  = 4'h9;
    localparam logic [3:0] c_OP_JEQ  = 4'hA;
    localparam logic [3:0] c_OP_JNE  = 4'hB;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic        dst_q, dst_d;
    logic [1:0]  sel_a_q, sel_a_d;
    logic [1:0]  sel_b_q, sel_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        ld_a_q, ld_a_d;
    logic        ld_b_q, ld_b_d;
    logic        mem_we_q, mem_we_d;
    logic        illegal_q, illegal_d;
    logic        pc_jmp_q, pc_jmp_d;
    logic        pc_jeq_q, pc_jeq_d;
    logic        pc_jne_q, pc_jne_d;
    logic [15:0] retired_q, retired_d;
    logic        w_load_dst;
    logic        w_in_exec;

    assign w_in_exec = (state_q == EXEC);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dst_d      = dst_q;
        retired_d  = retired_q + {15'd0, w_in_exec};
        sel_a_d    = 2'b11;
        sel_b_d    = 2'b11;
        alu_op_d   = 3'b000;
        mem_we_d   = 1'b0;
        illegal_d  = 1'b0;
        pc_jmp_d   = 1'b0;
        pc_jeq_d   = 1'b0;
        pc_jne_d   = 1'b0;
        w_load_dst = 1'b0;

        case (state_q)
            IDLE: begin
                if (ins_valid) begin
                    op_d    = ins_op;
                    dst_d   = ins_dst;
                    state_d = DEC;
                end
            end
            DEC:  state_d = (op_q == c_OP_LD) ? MEM : EXEC;
`ifdef CTRL_SEQ_MEMWAIT_EN
            MEM:  state_d = mem_ack ? EXEC : MEM;
`else
            MEM:  state_d = EXEC;
`endif
            EXEC: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so decode one cycle early for the EXEC cycle.
        if (state_d == EXEC) begin
            case (op_q)
                c_OP_NOP:  ;
                c_OP_MOVK: begin sel_b_d = 2'b10; w_load_dst = 1'b1; end
                c_OP_ADD:  begin sel_a_d = 2'b00; sel_b_d = 2'b00; w_load_dst = 1'b1; end
                c_OP_SUB:  begin sel_a_d = 2'b00; sel_b_d = 2'b00; alu_op_d = 3'b001; w_load_dst = 1'b1; end
                c_OP_AND:  begin sel_a_d = 2'b00; sel_b_d = 2'b00; alu_op_d = 3'b010; w_load_dst = 1'b1; end
                c_OP_OR:   begin sel_a_d = 2'b00; sel_b_d = 2'b00; alu_op_d = 3'b011; w_load_dst = 1'b1; end
                c_OP_INC:  begin sel_a_d = 2'b10; sel_b_d = 2'b00; w_load_dst = 1'b1; end
                c_OP_LD:   begin sel_b_d = 2'b01; w_load_dst = 1'b1; end
                c_OP_ST:   begin sel_a_d = 2'b00; mem_we_d = 1'b1; end
                c_OP_JMP:  pc_jmp_d = 1'b1;
                c_OP_JEQ:  pc_jeq_d = 1'b1;
                c_OP_JNE:  pc_jne_d = 1'b1;
                default:   illegal_d = 1'b1;
            endcase
        end

        ld_a_d = w_load_dst & ~dst_q;
        ld_b_d = w_load_dst &  dst_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 4'h0;
            dst_q     <= 1'b0;
            sel_a_q   <= 2'b11;
            sel_b_q   <= 2'b11;
            alu_op_q  <= 3'b000;
            ld_a_q    <= 1'b0;
            ld_b_q    <= 1'b0;
            mem_we_q  <= 1'b0;
            illegal_q <= 1'b0;
            pc_jmp_q  <= 1'b0;
            pc_jeq_q  <= 1'b0;
            pc_jne_q  <= 1'b0;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            alu_op_q  <= alu_op_d;
            ld_a_q    <= ld_a_d;
            ld_b_q    <= ld_b_d;
            mem_we_q  <= mem_we_d;
            illegal_q <= illegal_d;
            pc_jmp_q  <= pc_jmp_d;
            pc_jeq_q  <= pc_jeq_d;
            pc_jne_q  <= pc_jne_d;
            retired_q <= retired_d;
        end
    end

    // Branch condition must see flag_z live during EXEC, so only the jump kind is registered.
    assign pc_load   = pc_jmp_q | (pc_jeq_q & flag_z) | (pc_jne_q & ~flag_z);
    assign pc_inc    = w_in_exec & ~pc_load;
    assign ins_ready = (state_q == IDLE);
    assign sel_a     = sel_a_q;
    assign sel_b     = sel_b_q;
    assign alu_op    = alu_op_q;
    assign ld_a      = ld_a_q;
    assign ld_b      = ld_b_q;
    assign mem_we    = mem_we_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ctrl_seq                                                  |
// | Description : Self-checking bench for ctrl_seq against a per-instruction    |
// |               timing/decode model; honours CTRL_SEQ_MEMWAIT_EN if defined.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ctrl_seq;

    logic        clk;
    logic        rst_n;
    logic        ins_valid;
    logic        ins_ready;
    logic [3:0]  ins_op;
    logic        ins_dst;
    logic        flag_z;
    logic        mem_ack;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [2:0]  alu_op;
    logic        ld_a;
    logic        ld_b;
    logic        mem_we;
    logic        pc_inc;
    logic        pc_load;
    logic        illegal;
    logic [15:0] retired;

    int          checks;
    int          failures;
    logic [15:0] retired_m;

    // {sel_a, sel_b, alu_op, ld_a, ld_b, mem_we, pc_inc, pc_load, illegal}
    localparam logic [12:0] c_DEF = 13'b11_11_000_000000;

    ctrl_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_op    (ins_op),
        .ins_dst   (ins_dst),
        .flag_z    (flag_z),
`ifdef CTRL_SEQ_MEMWAIT_EN
        .mem_ack   (mem_ack),
`endif
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .alu_op    (alu_op),
        .ld_a      (ld_a),
        .ld_b      (ld_b),
        .mem_we    (mem_we),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .illegal   (illegal),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] exp_vec(input logic [3:0] op, input logic dst, input logic fz);
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic       ld;
        logic       we;
        logic       pcl;
        logic       ill;
        sa = 2'b11; sb = 2'b11; alu = 3'b000; ld = 1'b0; we = 1'b0; pcl = 1'b0; ill = 1'b0;
        case (op)
            4'h0: ;
            4'h1: begin sb = 2'b10; ld = 1'b1; end
            4'h2, 4'h3, 4'h4, 4'h5: begin sa = 2'b00; sb = 2'b00; alu = 3'(op - 4'h2); ld = 1'b1; end
            4'h6: begin sa = 2'b10; sb = 2'b00; ld = 1'b1; end
            4'h7: begin sb = 2'b01; ld = 1'b1; end
            4'h8: begin sa = 2'b00; we = 1'b1; end
            4'h9: pcl = 1'b1;
            4'hA: pcl = fz;
            4'hB: pcl = ~fz;
            default: ill = 1'b1;
        endcase
        return {sa, sb, alu, ld & ~dst, ld & dst, we, ~pcl, pcl, ill};
    endfunction

    // Entered and left at a falling edge with the sequencer idle.
    task automatic run_instr(input logic [3:0] op, input logic dst, input logic fz, input int waits_in);
        int          lat;
        int          waits;
        logic [12:0] got;
        logic [12:0] exp;
        logic [15:0] exp_ret;
        waits = waits_in;
`ifndef CTRL_SEQ_MEMWAIT_EN
        waits = 0;
`endif
        lat = (op == 4'h7) ? 3 + waits : 2;
        ins_valid = 1'b1;
        ins_op    = op;
        ins_dst   = dst;
        flag_z    = (lat == 1) ? fz : 1'($urandom);
        mem_ack   = 1'($urandom);
        checks++;
        if (ins_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_idle op=%h got=%b exp=1", op, ins_ready);
        end
        @(posedge clk);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            got = {sel_a, sel_b, alu_op, ld_a, ld_b, mem_we, pc_inc, pc_load, illegal};
            exp = (c == lat) ? exp_vec(op, dst, fz) : c_DEF;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL outputs op=%h dst=%b fz=%b cyc=T+%0d got=%b exp=%b", op, dst, fz, c + 1, got, exp);
            end
            checks++;
            if (ins_ready !== (c == lat + 1)) begin
                failures++;
                $display("FAIL ins_ready op=%h cyc=T+%0d got=%b exp=%b", op, c + 1, ins_ready, (c == lat + 1));
            end
            exp_ret = retired_m + ((c > lat) ? 16'd1 : 16'd0);
            checks++;
            if (retired !== exp_ret) begin
                failures++;
                $display("FAIL retired op=%h cyc=T+%0d got=%h exp=%h", op, c + 1, retired, exp_ret);
            end
            if (c <= lat) begin
                ins_valid = 1'($urandom);
                ins_op    = 4'($urandom);
                ins_dst   = 1'($urandom);
            end else begin
                ins_valid = 1'b0;
            end
            flag_z  = (c + 1 == lat) ? fz : 1'($urandom);
            mem_ack = (c < 2) ? 1'($urandom) : (c >= 2 + waits);
        end
        retired_m = retired_m + 16'd1;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got = {sel_a, sel_b, alu_op, ld_a, ld_b, mem_we, pc_inc, pc_load, illegal};
        checks++;
        if (got !== c_DEF) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", got, c_DEF); end
        checks++;
        if (ins_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ins_ready); end
        checks++;
        if (retired !== 16'h0000) begin failures++; $display("FAIL reset_retired got=%h exp=0000", retired); end
        rst_n = 1'b1;
        retired_m = 16'h0000;
        @(negedge clk);
        checks++;
        if (ins_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", ins_ready); end
    endtask

    task automatic test_movk();
        run_instr(4'h1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_ld();
        run_instr(4'h7, 1'b1, 1'b0, 0);
        run_instr(4'h7, 1'b1, 1'b1, 3);
        run_instr(4'h7, 1'b0, 1'b0, 1);
    endtask

    task automatic test_jumps();
        run_instr(4'hA, 1'b0, 1'b1, 0);
        run_instr(4'hA, 1'b0, 1'b0, 0);
        run_instr(4'hB, 1'b1, 1'b1, 0);
        run_instr(4'hB, 1'b1, 1'b0, 0);
        run_instr(4'h9, 1'b0, 1'b0, 0);
    endtask

    task automatic test_illegal();
        run_instr(4'hE, 1'b1, 1'b0, 0);
        run_instr(4'hC, 1'b0, 1'b1, 0);
    endtask

    task automatic test_reset_abort();
        logic [12:0] got;
        ins_valid = 1'b1;
        ins_op    = 4'h8;
        ins_dst   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ins_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        got = {sel_a, sel_b, alu_op, ld_a, ld_b, mem_we, pc_inc, pc_load, illegal};
        checks++;
        if (got !== c_DEF) begin failures++; $display("FAIL abort_outputs got=%b exp=%b", got, c_DEF); end
        checks++;
        if (ins_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", ins_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        retired_m = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0) begin failures++; $display("FAIL abort_mem_we cyc=%0d got=%b exp=0", i, mem_we); end
            checks++;
            if (retired !== 16'h0000) begin failures++; $display("FAIL abort_retired cyc=%0d got=%h exp=0000", i, retired); end
        end
    endtask

    task automatic test_wrap();
        force dut.retired_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.retired_q;
        retired_m = 16'hFFFF;
        run_instr(4'h2, 1'b1, 1'b0, 0);
        checks++;
        if (retired !== 16'h0000) begin failures++; $display("FAIL wrap got=%h exp=0000", retired); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            run_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        retired_m = 16'h0000;
        rst_n     = 1'b0;
        ins_valid = 1'b0;
        ins_op    = 4'h0;
        ins_dst   = 1'b0;
        flag_z    = 1'b0;
        mem_ack   = 1'b0;
        test_reset();
        test_movk();
        test_ld();
        test_jumps();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
